// File: rtl/bloom_addr_gen.sv
// bloom_addr_gen: steps a Galois LFSR seeded with a key once per clock and
// collects K bucket addresses (each folded into 0..SIZE-1). The packed set
// is presented with a one-cycle valid strobe for the downstream decoder.
module bloom_addr_gen #(
  parameter int                SIZE   = 8,
  parameter int                K      = 4,
  parameter int                BIT    = $clog2(SIZE),
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] TAPS   = 8'hB8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  data_in,
  output logic               ready,
  output logic               valid,
  output logic [K*BIT-1:0]   generated_addr
);

  localparam int               CNT_W    = $clog2(K) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);
  localparam logic [BIT:0]     SIZE_EXT = (BIT + 1)'(SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_lfsr;
  logic [CNT_W-1:0]    r_cnt;
  logic [K*BIT-1:0]    r_gen_addr;

  logic [DATA_W-1:0]   w_lfsr_nxt;
  logic [BIT-1:0]      w_raw;
  logic [BIT:0]        w_diff;
  logic [BIT-1:0]      w_addr;
  logic [DATA_W-1:0]   w_seed;

  // One Galois step; the new state's low bits become the raw address.
  assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign w_raw      = w_lfsr_nxt[BIT-1:0];
  // A single conditional subtract folds raw into range since 2^BIT < 2*SIZE.
  assign w_diff     = {1'b0, w_raw} - SIZE_EXT;
  assign w_addr     = ({1'b0, w_raw} >= SIZE_EXT) ? w_diff[BIT-1:0] : w_raw;
  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  assign w_seed     = (data_in == '0) ? DATA_W'(1) : data_in;

  // Outputs are pure state decodes or registers: no path from start/data_in.
  assign ready          = (r_state == IDLE);
  assign valid          = (r_state == DONE);
  assign generated_addr = r_gen_addr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    // NOTE: default assigned first so no path leaves the signal unassigned
    // and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = GEN;
      GEN:     if (r_cnt == LAST_CNT) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: seed on accept, then one LFSR step and one slot write per GEN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the packed address bank is a handful of flops, not a RAM, so it
      // is reset like any other register and a partial result is discarded.
      r_lfsr     <= DATA_W'(1);
      r_cnt      <= '0;
      r_gen_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_lfsr     <= w_seed;
            r_cnt      <= '0;
            r_gen_addr <= '0;
          end
        end
        GEN: begin
          r_lfsr <= w_lfsr_nxt;
          r_cnt  <= r_cnt + 1'b1;
          for (int i = 0; i < K; i++) begin
            if (r_cnt == CNT_W'(i)) r_gen_addr[BIT*i +: BIT] <= w_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_addr_gen.sv
// Directed bench for bloom_addr_gen: default instance (SIZE=8) and a SIZE=6
// instance share stimulus; expected values are hand-derived constants.
module tb_bloom_addr_gen;

  // Seed 1 walks B8,5C,2E,17 -> raw 0,4,6,7.
  localparam logic [11:0] EXP8 = {3'd7, 3'd6, 3'd4, 3'd0};  // 12'hFA0
  // SIZE=6 folds 6->0 and 7->1: slots 0,4,0,1.
  localparam logic [11:0] EXP6 = {3'd1, 3'd0, 3'd4, 3'd0};  // 12'h220

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  data_in;
  logic        ready8, valid8, ready6, valid6;
  logic [11:0] addr8, addr6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bloom_addr_gen dut8 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .ready(ready8), .valid(valid8), .generated_addr(addr8)
  );

  bloom_addr_gen #(.SIZE(6)) dut6 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .ready(ready6), .valid(valid6), .generated_addr(addr6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance one edge and sample 1 ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-pulse transaction with full cycle-by-cycle timing checks.
  task automatic run_key(input string tag, input logic [7:0] seed);
    int ready_low;
    data_in = seed;
    start   = 1'b1;
    tick();                                   // E0
    start   = 1'b0;
    data_in = 8'hC3;
    check({tag, "_e0_addr_cleared"}, addr8, 0);
    ready_low = 0;
    for (int e = 1; e <= 5; e++) begin
      if (!ready8) ready_low++;
      check({tag, "_valid"}, valid8, (e == 5) ? 1 : 0);
      tick();                                 // E1..E5
    end
    check({tag, "_ready_low_cycles"}, ready_low, 5);
    check({tag, "_valid_after_e5"}, valid8, 0);
    check({tag, "_ready_after_e5"}, ready8, 1);
    check({tag, "_addr8_held"}, addr8, EXP8);
    check({tag, "_addr6_held"}, addr6, EXP6);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    #2;
    check("reset_ready", ready8, 1);
    check("reset_valid", valid8, 0);
    check("reset_addr", addr8, 0);
    tick();
    rst = 1'b0;
    tick();

    // Seed 1, with an explicit look at the valid edge for both sizes.
    data_in = 8'h01;
    start   = 1'b1;
    tick();                                   // E0
    start   = 1'b0;
    check("t1_ready_e0", ready8, 0);
    tick(); tick(); tick();                   // E1..E3
    check("t1_valid_e3", valid8, 0);
    tick();                                   // E4
    check("t1_valid_e4", valid8, 1);
    check("t1_addr8", addr8, EXP8);
    check("t1_addr6", addr6, EXP6);
    check("t1_valid6", valid6, 1);
    tick();                                   // E5
    check("t1_valid_e5", valid8, 0);
    check("t1_ready_e5", ready8, 1);
    tick();
    check("t1_hold_idle", addr8, EXP8);

    // Full-timing run, then zero seed substituted by 1.
    run_key("seed01", 8'h01);
    run_key("seed00", 8'h00);

    // start re-pulsed during GEN with another key is ignored.
    data_in = 8'h01;
    start   = 1'b1;
    tick();                                   // E0
    start   = 1'b0;
    tick();                                   // E1
    data_in = 8'h5A;
    start   = 1'b1;
    tick();                                   // E2
    start   = 1'b0;
    pulses  = 0;
    for (int c = 0; c < 10; c++) begin
      if (valid8) pulses++;
      tick();
    end
    check("ignore_start_pulses", pulses, 1);
    check("ignore_start_addr", addr8, EXP8);
    check("ignore_start_ready", ready8, 1);

    // Reset after E2 discards the partial result immediately.
    data_in = 8'h01;
    start   = 1'b1;
    tick();                                   // E0
    start   = 1'b0;
    tick(); tick();                           // E1, E2
    check("pre_rst_partial", addr8, {3'd0, 3'd0, 3'd4, 3'd0});
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_addr", addr8, 0);
    check("mid_rst_valid", valid8, 0);
    check("mid_rst_ready", ready8, 1);
    check("mid_rst_addr6", addr6, 0);
    tick();
    rst = 1'b0;
    tick();
    run_key("after_rst", 8'h01);

    // start held high: back-to-back keys every 6 cycles.
    data_in = 8'h01;
    start   = 1'b1;
    tick();                                   // E0
    check("held_e0_addr", addr8, 0);
    pulses = 0;
    for (int e = 1; e <= 17; e++) begin
      tick();
      check("held_valid", valid8, (e % 6 == 4) ? 1 : 0);
      check("held_ready", ready8, (e % 6 == 5) ? 1 : 0);
      if (valid8) begin
        pulses++;
        check("held_addr", addr8, EXP8);
      end
      if (e % 6 == 0) check("held_reaccept_addr", addr8, 0);
    end
    start = 1'b0;
    check("held_pulses", pulses, 3);
    tick();
    check("held_idle_after_drop", ready8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
